// File: rtl/frame_sequencer_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the frame sequencer: FSM encoding and phase indices.
package frame_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PH_IN  = 2'd1,
        PH_UPD = 2'd2,
        PH_RND = 2'd3
    } seq_state_t;

    localparam int NUM_PHASES = 3;
    localparam int PH_IDX_IN  = 0;
    localparam int PH_IDX_UPD = 1;
    localparam int PH_IDX_RND = 2;

    // One-hot start mask for the subsystem with the given phase index.
    function automatic logic [NUM_PHASES-1:0] start_mask(input int idx);
        return NUM_PHASES'(1) << idx;
    endfunction

endpackage

// File: rtl/frame_sequencer_divider.sv
`timescale 1ns/1ps
// Frame-period divider: free-running 0..FRAME_DIV-1 counter that pauses while
// enable is low; tick decodes the terminal count qualified by enable.
module frame_divider #(
    parameter int FRAME_DIV = 1666667
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic tick
);

    localparam int               CNT_W    = $clog2(FRAME_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/frame_sequencer.sv
`timescale 1ns/1ps
// Frame scheduler: on each frame strobe runs input, update and render phases in
// order via start/done handshakes. Optional FRAME_SEQ_OVERRUN_STATS_EN adds a
// saturating dropped-strobe counter on overrun_total.
module frame_sequencer
    import frame_sequencer_pkg::*;
#(
    parameter int FRAME_DIV = 1666667,
    parameter int FCNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [NUM_PHASES-1:0] phase_done,
    output logic                  frame_tick,
    output logic [NUM_PHASES-1:0] phase_start,
    output logic                  busy,
    output logic [FCNT_W-1:0]     frame_count,
    output logic                  overrun,
    output logic [7:0]            overrun_total
);

    seq_state_t            state, state_nxt;
    logic [NUM_PHASES-1:0] phase_start_nxt;
    logic                  overrun_nxt;
    logic                  frame_done;

    frame_divider #(
        .FRAME_DIV (FRAME_DIV)
    ) u_divider (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .tick   (frame_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            phase_start <= '0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
        end else begin
            state       <= state_nxt;
            phase_start <= phase_start_nxt;
            busy        <= (state_nxt != IDLE);
            overrun     <= overrun_nxt;
            if (frame_done) begin
                frame_count <= frame_count + FCNT_W'(1);
            end
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_tick)             state_nxt = PH_IN;
            PH_IN:   if (phase_done[PH_IDX_IN])  state_nxt = PH_UPD;
            PH_UPD:  if (phase_done[PH_IDX_UPD]) state_nxt = PH_RND;
            PH_RND:  if (phase_done[PH_IDX_RND]) state_nxt = frame_tick ? PH_IN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A strobe landing mid-frame is dropped, except when it coincides with render done.
    always_comb begin
        phase_start_nxt = '0;
        overrun_nxt     = 1'b0;
        frame_done      = 1'b0;
        case (state)
            IDLE: begin
                if (frame_tick) phase_start_nxt = start_mask(PH_IDX_IN);
            end
            PH_IN: begin
                if (phase_done[PH_IDX_IN]) phase_start_nxt = start_mask(PH_IDX_UPD);
                overrun_nxt = frame_tick;
            end
            PH_UPD: begin
                if (phase_done[PH_IDX_UPD]) phase_start_nxt = start_mask(PH_IDX_RND);
                overrun_nxt = frame_tick;
            end
            PH_RND: begin
                if (phase_done[PH_IDX_RND]) begin
                    frame_done = 1'b1;
                    if (frame_tick) phase_start_nxt = start_mask(PH_IDX_IN);
                end else begin
                    overrun_nxt = frame_tick;
                end
            end
            default: ;
        endcase
    end

`ifdef FRAME_SEQ_OVERRUN_STATS_EN
    localparam logic [7:0] OVR_TOTAL_MAX = 8'hFF;

    logic [7:0] ovr_total_q;

    // Counts alongside the registered overrun pulse so both change on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovr_total_q <= '0;
        end else if (overrun_nxt && (ovr_total_q != OVR_TOTAL_MAX)) begin
            ovr_total_q <= ovr_total_q + 8'd1;
        end
    end

    assign overrun_total = ovr_total_q;
`else
    assign overrun_total = 8'd0;
`endif

endmodule

// File: tb/tb_frame_sequencer.sv
`timescale 1ns/1ps
// Directed bench for frame_sequencer with FRAME_DIV = 8 and FCNT_W = 4.
module tb_frame_sequencer;

`ifdef FRAME_SEQ_OVERRUN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b0;
    logic [2:0] phase_done = 3'b000;
    logic       frame_tick;
    logic [2:0] phase_start;
    logic       busy;
    logic [3:0] frame_count;
    logic       overrun;
    logic [7:0] overrun_total;

    int n_checks = 0;
    int n_pass   = 0;

    frame_sequencer #(
        .FRAME_DIV (8),
        .FCNT_W    (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .phase_done    (phase_done),
        .frame_tick    (frame_tick),
        .phase_start   (phase_start),
        .busy          (busy),
        .frame_count   (frame_count),
        .overrun       (overrun),
        .overrun_total (overrun_total)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic [2:0] done;
        logic       exp_tick;
        logic [2:0] exp_start;
        logic       exp_busy;
        logic       exp_ovr;
        logic [3:0] exp_fc;
    } vec_t;

    vec_t vecs [15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Inputs change 1 ns after the edge; outputs are sampled 1 ns later.
    task automatic cyc(input logic r, input logic en, input logic [2:0] done);
        @(posedge clk);
        #1;
        rst        = r;
        enable     = en;
        phase_done = done;
        #1;
    endtask

    task automatic do_reset();
        cyc(1'b1, 1'b0, 3'b000);
        cyc(1'b1, 1'b0, 3'b000);
    endtask

    task automatic check_outs(input string tag, input logic tk, input logic [2:0] st,
                              input logic b, input logic ov, input logic [3:0] fc);
        check({tag, ".tick"},  32'(frame_tick),  32'(tk));
        check({tag, ".start"}, 32'(phase_start), 32'(st));
        check({tag, ".busy"},  32'(busy),        32'(b));
        check({tag, ".ovr"},   32'(overrun),     32'(ov));
        check({tag, ".fc"},    32'(frame_count), 32'(fc));
    endtask

    initial begin
        // Steady frame: each subsystem answers one cycle after its start.
        vecs[0]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
        vecs[1]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
        vecs[2]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
        vecs[3]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
        vecs[4]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
        vecs[5]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
        vecs[6]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd0};
        vecs[7]  = '{1'b1, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 4'd0};
        vecs[8]  = '{1'b1, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 4'd0};
        vecs[9]  = '{1'b1, 3'b001, 1'b0, 3'b000, 1'b1, 1'b0, 4'd0};
        vecs[10] = '{1'b1, 3'b000, 1'b0, 3'b010, 1'b1, 1'b0, 4'd0};
        vecs[11] = '{1'b1, 3'b010, 1'b0, 3'b000, 1'b1, 1'b0, 4'd0};
        vecs[12] = '{1'b1, 3'b000, 1'b0, 3'b100, 1'b1, 1'b0, 4'd0};
        vecs[13] = '{1'b1, 3'b100, 1'b0, 3'b000, 1'b1, 1'b0, 4'd0};
        vecs[14] = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 1'b0, 4'd1};

        do_reset();
        check("reset.ovr_total", 32'(overrun_total), 32'd0);
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, vecs[i].en, vecs[i].done);
            check_outs($sformatf("steady.c%0d", i), vecs[i].exp_tick, vecs[i].exp_start,
                       vecs[i].exp_busy, vecs[i].exp_ovr, vecs[i].exp_fc);
        end

        // Update phase stalls through ticks at 15 and 23; render done meets tick at 31.
        do_reset();
        for (int c = 0; c <= 34; c++) begin
            logic [2:0] d;
            logic [2:0] st;
            d  = 3'b000;
            st = 3'b000;
            if (c == 9)  d = 3'b001;
            if (c == 30) d = 3'b010;
            if (c == 31) d = 3'b100;
            if (c == 33) d = 3'b001;
            if (c == 8 || c == 32) st = 3'b001;
            if (c == 10 || c == 34) st = 3'b010;
            if (c == 31) st = 3'b100;
            cyc(1'b0, 1'b1, d);
            check_outs($sformatf("stall.c%0d", c), (c % 8) == 7, st, c >= 8,
                       (c == 16) || (c == 24), (c >= 32) ? 4'd1 : 4'd0);
            if (c == 16) check("stall.ovr_total1", 32'(overrun_total), STATS ? 32'd1 : 32'd0);
            if (c == 32) check("stall.ovr_total2", 32'(overrun_total), STATS ? 32'd2 : 32'd0);
        end

        // Done bits for other phases are ignored while in PH_IN.
        do_reset();
        for (int c = 0; c <= 12; c++) begin
            logic [2:0] d;
            logic [2:0] st;
            d  = 3'b000;
            st = 3'b000;
            if (c == 9)  d = 3'b100;
            if (c == 10) d = 3'b010;
            if (c == 11) d = 3'b001;
            if (c == 8)  st = 3'b001;
            if (c == 12) st = 3'b010;
            cyc(1'b0, 1'b1, d);
            check_outs($sformatf("wrong.c%0d", c), c == 7, st, c >= 8, 1'b0, 4'd0);
        end

        // Enable low for 5 cycles at cnt 3 delays the tick to 12; reset lands in PH_UPD.
        do_reset();
        for (int c = 0; c <= 19; c++) begin
            logic [2:0] d;
            logic [2:0] st;
            d  = (c == 14) ? 3'b001 : 3'b000;
            st = 3'b000;
            if (c == 13) st = 3'b001;
            if (c == 15) st = 3'b010;
            cyc(c == 16, !(c >= 3 && c <= 7), d);
            check_outs($sformatf("enable.c%0d", c), c == 12, st, (c >= 13) && (c <= 16),
                       1'b0, 4'd0);
        end

        // Sixteen complete frames wrap the 4-bit frame counter.
        do_reset();
        begin
            logic [2:0] pend;
            pend = 3'b000;
            for (int c = 0; c <= 134; c++) begin
                cyc(1'b0, 1'b1, pend);
                pend = phase_start;
                if (c == 126) check("wrap.fc15", 32'(frame_count), 32'd15);
                if (c == 133) check("wrap.fc15_hold", 32'(frame_count), 32'd15);
                if (c == 134) begin
                    check("wrap.fc0", 32'(frame_count), 32'd0);
                    check("wrap.busy", 32'(busy), 32'd0);
                end
            end
        end

        // Input phase never answers: 300 dropped strobes saturate the statistic.
        do_reset();
        begin
            int n_ovr;
            n_ovr = 0;
            for (int c = 0; c <= 2412; c++) begin
                cyc(1'b0, 1'b1, 3'b000);
                if (overrun) n_ovr++;
                if (c == 16) begin
                    check("sat.first_ovr", 32'(overrun), 32'd1);
                    check("sat.total1", 32'(overrun_total), STATS ? 32'd1 : 32'd0);
                end
                if (c == 2040) check("sat.total254", 32'(overrun_total), STATS ? 32'd254 : 32'd0);
                if (c == 2048) check("sat.total255", 32'(overrun_total), STATS ? 32'd255 : 32'd0);
            end
            check("sat.ovr_pulses", 32'(n_ovr), 32'd300);
            check("sat.total_final", 32'(overrun_total), STATS ? 32'd255 : 32'd0);
            check("sat.busy", 32'(busy), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level scheduler for the game core. It derives a periodic frame strobe from `clk` through an internal divider. On each strobe it runs three subsystems in a fixed order using a start/done handshake: input sampling, game-state update, then render-buffer commit. It sits between the top module's clock and the input, physics and render controllers, and is the single owner of frame timing.

## Interface
Parameters:
- `FRAME_DIV`, default 1666667: frame period in `clk` cycles (60 Hz at 100 MHz). Must be ≥ 4.
- `FCNT_W`, default 16: width of `frame_count`.

Ports:
- `clk` in 1: system clock. All logic is on the rising edge.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `enable` in 1: when low, the divider holds its count and no new frame starts. A frame already in progress runs to completion.
- `phase_done` in 3: one-cycle done pulse from subsystem i. Bit 0 = input, bit 1 = update, bit 2 = render.
- `frame_tick` out 1: one-cycle frame-boundary strobe.
- `phase_start` out 3: one-hot, one-cycle start pulse to subsystem i.
- `busy` out 1: high while a frame is in progress (any phase state).
- `frame_count` out `FCNT_W`: number of completed frames; wraps to 0.
- `overrun` out 1: one-cycle pulse when a frame strobe is dropped.
- `overrun_total` out 8: saturating count of dropped strobes. Requires the macro in Configuration.

## Operation
- Divider `cnt` counts 0 → `FRAME_DIV`-1 and wraps.
  - It advances only while `enable` = 1.
  - `frame_tick` = `enable` && (`cnt` == `FRAME_DIV`-1).
- FSM states: IDLE, PH_IN, PH_UPD, PH_RND.
- IDLE:
  - On `frame_tick`: next state is PH_IN, and `phase_start[0]` pulses in the next cycle.
- Phase i (PH_IN = 0, PH_UPD = 1, PH_RND = 2):
  - Waits for `phase_done[i]`.
  - On `phase_done[i]` with i < 2: advance to phase i+1 and pulse `phase_start[i+1]` in the next cycle.
  - `phase_done` bits other than the current phase's are ignored.
- PH_RND with `phase_done[2]`:
  - Increment `frame_count`.
  - Return to IDLE.
- Simultaneous `phase_done[2]` and `frame_tick` in PH_RND:
  - The current frame completes and `frame_count` increments.
  - The FSM goes directly to PH_IN and pulses `phase_start[0]` next cycle.
  - No overrun is flagged.
- `frame_tick` while in PH_IN, PH_UPD, or PH_RND (other than the case above):
  - The strobe is dropped.
  - `overrun` pulses in the next cycle.
  - FSM state is unchanged.
- No timeout. A subsystem that never returns done stalls the sequencer; the stall is visible as repeated overruns.
- `enable` deassertion does not abort a frame in progress.

## Timing
- Reset values:
  - `cnt` = 0, state IDLE.
  - `phase_start` = 0, `overrun` = 0, `busy` = 0.
  - `frame_count` = 0, `overrun_total` = 0.
- `rst` asserted mid-frame aborts the frame on the next edge. No `phase_start` pulse follows.
- Cycle 0 is the first cycle with `rst` = 0. With `enable` = 1 throughout:
  - First `frame_tick` is in cycle `FRAME_DIV`-1.
  - Subsequent ticks follow every `FRAME_DIV` cycles.
- Handshake latencies:
  - `frame_tick` → `phase_start[0]`: 1 cycle.
  - `phase_done[i]` → `phase_start[i+1]`: 1 cycle.
  - `phase_done[2]` → `frame_count` update and `busy` low: 1 cycle.
- `busy` rises in the same cycle as `phase_start[0]`.
- All outputs are registered except `frame_tick`, which is a decode of registered `cnt` and the `enable` input.

## Configuration
- `FRAME_SEQ_OVERRUN_STATS_EN` defined:
  - `overrun_total` increments on every `overrun` pulse.
  - It saturates at 255 and clears only on `rst`.
- Not defined:
  - The counter logic is omitted.
  - `overrun_total` is tied to 0.
  - `overrun` pulses are unaffected.

## Structure
- Shared package holds:
  - the FSM state encoding (2-bit);
  - phase index constants `PH_IDX_IN` = 0, `PH_IDX_UPD` = 1, `PH_IDX_RND` = 2;
  - `NUM_PHASES` = 3.
- One sub-module, `frame_divider`:
  - parameter `FRAME_DIV`;
  - ports `clk`, `rst`, `enable`, `tick`;
  - counter width `$clog2(FRAME_DIV)`.
- The FSM, handshake and statistics live in `frame_sequencer`.

## Test plan
Unless stated otherwise, `FRAME_DIV` = 8.

1. Steady sequence, each subsystem answering 1 cycle after its start:
   - first `frame_tick` at cycle 7;
   - `phase_start` = 001 at cycle 8, 010 at 10, 100 at 12;
   - `frame_count` = 1 and `busy` = 0 at cycle 14.
2. Stalled update phase (no `phase_done[1]` for 20 cycles):
   - `overrun` pulses 1 cycle after each of the 2 ticks that fall in the stall;
   - state stays PH_UPD;
   - with the macro, `overrun_total` = 2.
3. `phase_done[2]` coincident with `frame_tick`:
   - `frame_count` increments;
   - `phase_start[0]` follows next cycle;
   - `overrun` stays 0.
4. Wrong-phase done (`phase_done[2]` pulsed during PH_IN):
   - ignored: no state change and no `phase_start`.
5. `enable` held low for 5 cycles at `cnt` = 3:
   - next tick is delayed by exactly 5 cycles;
   - `rst` asserted during PH_UPD returns all outputs to 0 on the next edge.
6. Wrap and saturation, with `FCNT_W` = 4:
   - 16 completed frames give `frame_count` = 0;
   - 300 forced overruns give `overrun_total` = 255 with the macro, 0 without.
